// File: rtl/lpif_dstrm_protid_sched_pkg.sv
// Shared types and constants for the LPIF downstream protocol-ID scheduler.
package lpif_sched_pkg;

  // Link state code reported by the LSM when the link may carry flits.
  localparam logic [3:0] LPIF_ST_ACTIVE = 4'h1;

  // Field widths of the dstrm_* bundle.
  localparam int PROTID_W = 2;
  localparam int STATE_W  = 4;

  // Packet scheduler states: free, packet owned, packet paused by link state.
  typedef enum logic [1:0] {
    SCH_IDLE = 2'd0,
    SCH_LOCK = 2'd1,
    SCH_HOLD = 2'd2
  } sched_st_t;

endpackage

// File: rtl/lpif_dstrm_protid_sched_arb.sv
// Combinational round-robin pick: first asserted request strictly after the
// pointer, wrapping around. The pointer register lives in the parent.
module lpif_rr_arb
  import lpif_sched_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]          i_req,
  input  logic [PROTID_W-1:0]   i_ptr,
  output logic [PROTID_W-1:0]   o_grant,
  output logic                  o_any
);

  logic [3:0]          w_req4;
  logic [PROTID_W-1:0] w_idx;
  logic                w_hit;

  assign w_req4 = 4'(i_req);

  // Scan requesters in cyclic order starting just after the pointer.
  always_comb begin
    o_grant = 2'd0;
    o_any   = 1'b0;
    w_idx   = 2'd0;
    w_hit   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      w_idx   = 2'((int'(i_ptr) + k) % N);
      w_hit   = ~o_any & w_req4[w_idx];
      o_grant = w_hit ? w_idx : o_grant;
      o_any   = o_any | w_hit;
    end
  end

endmodule

// File: rtl/lpif_dstrm_protid_sched.sv
// Downstream scheduler: shares one dstrm_* channel among NUM_REQ protocol-ID
// requesters with round-robin grant at packet boundaries, issue-slot pacing
// and gating of data on link ACTIVE state.
module lpif_dstrm_protid_sched
  import lpif_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 256,
  parameter int CRC_W   = 16
) (
  input  logic                      clk_wr,
  input  logic                      rst_wr,
  input  logic                      m_gen2_mode,
  input  logic [STATE_W-1:0]        lp_state,
  input  logic                      tx_ready,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*CRC_W-1:0]  req_crc,
  input  logic [NUM_REQ-1:0]        req_crc_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [STATE_W-1:0]        dstrm_state,
  output logic [PROTID_W-1:0]       dstrm_protid,
  output logic [DATA_W-1:0]         dstrm_data,
  output logic                      dstrm_dvalid,
  output logic [CRC_W-1:0]          dstrm_crc,
  output logic                      dstrm_crc_valid,
  output logic                      dstrm_valid,
  output logic                      sched_busy
);

  sched_st_t             r_state, w_state_nxt;
  logic [PROTID_W-1:0]   r_owner, w_owner_nxt;
  logic [PROTID_W-1:0]   r_ptr;
  logic                  r_pace;
  logic                  r_busy;

  logic [STATE_W-1:0]    r_dstrm_state;
  logic [PROTID_W-1:0]   r_dstrm_protid;
  logic [DATA_W-1:0]     r_dstrm_data;
  logic                  r_dstrm_dvalid;
  logic [CRC_W-1:0]      r_dstrm_crc;
  logic                  r_dstrm_crc_valid;
  logic                  r_dstrm_valid;

  logic                  w_slot, w_issue, w_active, w_can, w_xfer_ok, w_xfer;
  logic [PROTID_W-1:0]   w_arb_grant, w_grant;
  logic                  w_arb_any;
  logic [NUM_REQ-1:0]    w_ready;
  logic                  w_sel_last, w_sel_crcv;
  logic [DATA_W-1:0]     w_sel_data;
  logic [CRC_W-1:0]      w_sel_crc;

  // Gen2 issues every cycle; otherwise only on odd cycles of the pace toggle.
  assign w_slot    = m_gen2_mode | r_pace;
  assign w_issue   = w_slot & tx_ready;
  assign w_active  = (lp_state == LPIF_ST_ACTIVE);
  // Handshake is forced low while reset is asserted so every output reads 0.
  assign w_xfer_ok = w_issue & w_active & w_can & ~rst_wr;
  assign w_xfer    = |w_ready;

  lpif_rr_arb #(.N(NUM_REQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_any   (w_arb_any)
  );

  // FSM output decode: who holds the grant and whether it may transfer now.
  always_comb begin
    w_grant = r_owner;
    w_can   = 1'b0;
    case (r_state)
      SCH_IDLE: begin w_grant = w_arb_grant; w_can = w_arb_any; end
      SCH_LOCK: begin w_grant = r_owner;     w_can = 1'b1;      end
      SCH_HOLD: begin w_grant = r_owner;     w_can = 1'b0;      end
      default:  begin w_grant = 2'd0;        w_can = 1'b0;      end
    endcase
  end

  // Per-requester handshake and selection of the granted slice.
  always_comb begin
    w_ready    = {NUM_REQ{1'b0}};
    w_sel_last = 1'b0;
    w_sel_crcv = 1'b0;
    w_sel_data = {DATA_W{1'b0}};
    w_sel_crc  = {CRC_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      w_ready[i] = w_xfer_ok & (w_grant == 2'(i)) & req_valid[i];
      w_sel_last = (w_grant == 2'(i)) ? req_last[i]                  : w_sel_last;
      w_sel_crcv = (w_grant == 2'(i)) ? req_crc_valid[i]             : w_sel_crcv;
      w_sel_data = (w_grant == 2'(i)) ? req_data[i*DATA_W +: DATA_W] : w_sel_data;
      w_sel_crc  = (w_grant == 2'(i)) ? req_crc[i*CRC_W +: CRC_W]    : w_sel_crc;
    end
  end

  // Next-state logic: lock on a multi-flit packet, pause while link not ACTIVE.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      SCH_IDLE: begin
        if (w_xfer && !w_sel_last) begin
          w_state_nxt = SCH_LOCK;
          w_owner_nxt = w_grant;
        end else begin
          w_state_nxt = SCH_IDLE;
        end
      end
      SCH_LOCK: begin
        if (!w_active) begin
          w_state_nxt = SCH_HOLD;
        end else if (w_xfer && w_sel_last) begin
          w_state_nxt = SCH_IDLE;
        end else begin
          w_state_nxt = SCH_LOCK;
        end
      end
      SCH_HOLD: begin
        if (w_active) begin
          w_state_nxt = SCH_LOCK;
        end else begin
          w_state_nxt = SCH_HOLD;
        end
      end
      default: begin
        w_state_nxt = SCH_IDLE;
      end
    endcase
  end

  // State register, owner, round-robin pointer and pace toggle.
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      r_state <= SCH_IDLE;
      r_owner <= 2'd0;
      r_ptr   <= 2'(NUM_REQ - 1);
      r_pace  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_xfer ? w_grant : r_ptr;
      r_pace  <= ~r_pace;
      r_busy  <= (w_state_nxt != SCH_IDLE);
    end
  end

  // Registered dstrm_* bundle; payload fields hold when no flit is carried.
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      r_dstrm_valid     <= 1'b0;
      r_dstrm_state     <= 4'h0;
      r_dstrm_dvalid    <= 1'b0;
      r_dstrm_protid    <= 2'd0;
      r_dstrm_data      <= {DATA_W{1'b0}};
      r_dstrm_crc       <= {CRC_W{1'b0}};
      r_dstrm_crc_valid <= 1'b0;
    end else begin
      r_dstrm_valid <= w_issue;
      r_dstrm_state <= w_issue ? lp_state : r_dstrm_state;
      if (w_xfer) begin
        r_dstrm_dvalid    <= 1'b1;
        r_dstrm_protid    <= w_grant;
        r_dstrm_data      <= w_sel_data;
        r_dstrm_crc       <= w_sel_crc;
        r_dstrm_crc_valid <= w_sel_crcv;
      end else begin
        r_dstrm_dvalid    <= 1'b0;
        r_dstrm_crc_valid <= 1'b0;
      end
    end
  end

  assign req_ready       = w_ready;
  assign dstrm_state     = r_dstrm_state;
  assign dstrm_protid    = r_dstrm_protid;
  assign dstrm_data      = r_dstrm_data;
  assign dstrm_dvalid    = r_dstrm_dvalid;
  assign dstrm_crc       = r_dstrm_crc;
  assign dstrm_crc_valid = r_dstrm_crc_valid;
  assign dstrm_valid     = r_dstrm_valid;
  assign sched_busy      = r_busy;

endmodule

// File: tb/tb_lpif_dstrm_protid_sched.sv
// Self-checking bench for lpif_dstrm_protid_sched: directed vector table,
// hand-written multi-cycle sequences and randomized traffic, all compared
// each cycle against a packet-level reference model.
module tb_lpif_dstrm_protid_sched;

  localparam int N  = 2;
  localparam int DW = 256;
  localparam int CW = 16;

  logic          clk_wr = 1'b0;
  logic          rst_wr = 1'b0;
  logic          gen2 = 1'b1;
  logic [3:0]    lp = 4'h1;
  logic          tx = 1'b1;
  logic [N-1:0]  rv = '0, rl = '0, rcv = '0;
  logic [N*DW-1:0] rd = '0;
  logic [N*CW-1:0] rc = '0;

  logic [N-1:0]  req_ready;
  logic [3:0]    dstrm_state;
  logic [1:0]    dstrm_protid;
  logic [DW-1:0] dstrm_data;
  logic          dstrm_dvalid;
  logic [CW-1:0] dstrm_crc;
  logic          dstrm_crc_valid;
  logic          dstrm_valid;
  logic          sched_busy;

  lpif_dstrm_protid_sched #(.NUM_REQ(N), .DATA_W(DW), .CRC_W(CW)) dut (
    .clk_wr(clk_wr), .rst_wr(rst_wr), .m_gen2_mode(gen2), .lp_state(lp),
    .tx_ready(tx), .req_valid(rv), .req_last(rl), .req_data(rd), .req_crc(rc),
    .req_crc_valid(rcv), .req_ready(req_ready), .dstrm_state(dstrm_state),
    .dstrm_protid(dstrm_protid), .dstrm_data(dstrm_data),
    .dstrm_dvalid(dstrm_dvalid), .dstrm_crc(dstrm_crc),
    .dstrm_crc_valid(dstrm_crc_valid), .dstrm_valid(dstrm_valid),
    .sched_busy(sched_busy)
  );

  always #5 clk_wr = ~clk_wr;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: packet owner (-1 = none), paused flag, last-served index,
  // cycles since reset, and the expected registered bundle.
  int       k, owner, ptr, m_cand;
  bit       held, m_issue, m_act;
  logic [N-1:0]  m_ready, obs_ready;
  logic          e_valid, e_dvalid, e_crcv, e_busy;
  logic [3:0]    e_state;
  logic [1:0]    e_protid;
  logic [DW-1:0] e_data;
  logic [CW-1:0] e_crc;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] fdat(input int r, input int n);
    return {160'h0, 32'hC0FFEE00, 32'(r), 32'(n)};
  endfunction

  task automatic set_slice(input int r, input int n);
    rd[r*DW +: DW] = fdat(r, n);
    rc[r*CW +: CW] = 16'(n * 7 + r + 1);
  endtask

  task automatic model_reset();
    k = 0; owner = -1; held = 1'b0; ptr = N - 1;
    e_valid = 1'b0; e_dvalid = 1'b0; e_crcv = 1'b0; e_busy = 1'b0;
    e_state = 4'h0; e_protid = 2'd0; e_data = '0; e_crc = '0;
  endtask

  task automatic model_pre();
    int j;
    bit slot;
    slot    = gen2 || (k % 2 == 1);
    m_issue = slot && tx;
    m_act   = (lp == 4'h1);
    m_cand  = -1;
    if (owner < 0) begin
      for (int off = 1; off <= N; off++) begin
        j = (ptr + off) % N;
        for (int q = 0; q < N; q++)
          if (q == j && m_cand < 0 && rv[q]) m_cand = q;
      end
    end else if (!held) begin
      m_cand = owner;
    end
    m_ready = '0;
    for (int q = 0; q < N; q++)
      if (m_issue && m_act && m_cand == q && rv[q]) m_ready[q] = 1'b1;
  endtask

  task automatic model_commit();
    bit last;
    e_valid = m_issue;
    if (m_issue) e_state = lp;
    if (m_ready != '0) begin
      last = 1'b0;
      for (int q = 0; q < N; q++)
        if (m_ready[q]) begin
          last = rl[q]; e_crcv = rcv[q];
          e_data = rd[q*DW +: DW]; e_crc = rc[q*CW +: CW];
        end
      e_dvalid = 1'b1;
      e_protid = 2'(m_cand);
      ptr = m_cand;
      if (owner < 0) begin
        if (!last) owner = m_cand;
      end else if (last) begin
        owner = -1;
      end
    end else begin
      e_dvalid = 1'b0;
      e_crcv = 1'b0;
      if (owner >= 0) begin
        if (held && m_act) held = 1'b0;
        else if (!held && !m_act) held = 1'b1;
      end
    end
    e_busy = (owner >= 0);
    k++;
  endtask

  // One clock: check handshake mid-cycle, then the registered bundle after the edge.
  task automatic step();
    @(negedge clk_wr);
    model_pre();
    obs_ready = req_ready;
    chk("req_ready", obs_ready, m_ready);
    model_commit();
    @(posedge clk_wr);
    #1;
    chk("dstrm_valid", dstrm_valid, e_valid);
    chk("dstrm_state", dstrm_state, e_state);
    chk("dstrm_dvalid", dstrm_dvalid, e_dvalid);
    chk("dstrm_protid", dstrm_protid, e_protid);
    chk("dstrm_data", dstrm_data, e_data);
    chk("dstrm_crc", dstrm_crc, e_crc);
    chk("dstrm_crc_valid", dstrm_crc_valid, e_crcv);
    chk("sched_busy", sched_busy, e_busy);
  endtask

  // Assert reset, check that outputs clear immediately, release after one edge.
  task automatic rst_pulse();
    rst_wr = 1'b1;
    #1;
    model_reset();
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", dstrm_valid, 0);
    chk("rst_state", dstrm_state, 0);
    chk("rst_dvalid", dstrm_dvalid, 0);
    chk("rst_protid", dstrm_protid, 0);
    chk("rst_data", dstrm_data, 0);
    chk("rst_crc", dstrm_crc, 0);
    chk("rst_crcv", dstrm_crc_valid, 0);
    chk("rst_busy", sched_busy, 0);
    @(posedge clk_wr);
    #1;
    rst_wr = 1'b0;
  endtask

  typedef struct {
    bit         pre_rst;
    logic [1:0] rv;
    logic [1:0] rl;
    logic [1:0] exp_ready;
    logic       exp_dvalid;
    logic [1:0] exp_protid;
  } vec_t;

  vec_t tbl [8];
  int   n;

  initial begin
    // Both requesters with single-flit packets: strict alternation from req 0.
    tbl[0] = '{1'b1, 2'b11, 2'b11, 2'b01, 1'b1, 2'd0};
    tbl[1] = '{1'b0, 2'b11, 2'b11, 2'b10, 1'b1, 2'd1};
    tbl[2] = '{1'b0, 2'b11, 2'b11, 2'b01, 1'b1, 2'd0};
    tbl[3] = '{1'b0, 2'b11, 2'b11, 2'b10, 1'b1, 2'd1};
    // req0 3-flit packet; req1 waits from flit 1 until after req0's last.
    tbl[4] = '{1'b1, 2'b01, 2'b00, 2'b01, 1'b1, 2'd0};
    tbl[5] = '{1'b0, 2'b11, 2'b10, 2'b01, 1'b1, 2'd0};
    tbl[6] = '{1'b0, 2'b11, 2'b11, 2'b01, 1'b1, 2'd0};
    tbl[7] = '{1'b0, 2'b10, 2'b10, 2'b10, 1'b1, 2'd1};

    model_reset();
    #2;
    rst_pulse();

    // Gen2, ACTIVE: req0 4-flit packet goes out on consecutive cycles in order.
    gen2 = 1'b1; lp = 4'h1; tx = 1'b1; rcv = 2'b11;
    for (int f = 0; f < 4; f++) begin
      rv = 2'b01; rl = {1'b0, (f == 3)};
      set_slice(0, f);
      step();
      chk("t1_ready", obs_ready, 2'b01);
      chk("t1_dvalid", dstrm_dvalid, 1);
      chk("t1_protid", dstrm_protid, 0);
      chk("t1_data", dstrm_data, fdat(0, f));
    end
    rv = 2'b00; rl = 2'b00;
    step();
    chk("t1_idle_dvalid", dstrm_dvalid, 0);

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].pre_rst) rst_pulse();
      gen2 = 1'b1; lp = 4'h1; tx = 1'b1;
      rv = tbl[i].rv; rl = tbl[i].rl;
      set_slice(0, i); set_slice(1, i);
      step();
      chk("tbl_ready", obs_ready, tbl[i].exp_ready);
      chk("tbl_dvalid", dstrm_dvalid, tbl[i].exp_dvalid);
      chk("tbl_protid", dstrm_protid, tbl[i].exp_protid);
      chk("tbl_data", dstrm_data, fdat(int'(tbl[i].exp_protid), i));
    end

    // Half-rate pacing: issue slots only on odd cycles after reset.
    rst_pulse();
    gen2 = 1'b0; rv = 2'b01; rl = 2'b00;
    for (int c = 0; c < 8; c++) begin
      set_slice(0, c);
      step();
      chk("t4_ready", obs_ready, (c % 2 == 1) ? 2'b01 : 2'b00);
      chk("t4_valid", dstrm_valid, (c % 2 == 1));
    end
    gen2 = 1'b1;

    // Link leaves ACTIVE after flit 2 of 5: HOLD, then resume the same packet.
    rst_pulse();
    rv = 2'b01; n = 0;
    for (int c = 0; c < 2; c++) begin
      rl = 2'b00; set_slice(0, n);
      step();
      if (obs_ready[0]) n++;
    end
    chk("t5_pre_count", n, 2);
    lp = 4'h3;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("t5_hold_ready", obs_ready, 2'b00);
      chk("t5_hold_busy", sched_busy, 1);
      chk("t5_hold_dvalid", dstrm_dvalid, 0);
      chk("t5_hold_state", dstrm_state, 4'h3);
    end
    lp = 4'h1;
    for (int c = 0; c < 6 && n < 5; c++) begin
      rl = {1'b0, (n == 4)}; set_slice(0, n);
      step();
      if (obs_ready[0]) begin
        chk("t5_res_protid", dstrm_protid, 0);
        chk("t5_res_data", dstrm_data, fdat(0, n));
        n++;
      end
    end
    chk("t5_flit_count", n, 5);
    rv = 2'b00; rl = 2'b00;
    step();
    chk("t5_end_busy", sched_busy, 0);

    // tx_ready low mid-packet stalls transfers; reset then abandons the packet.
    rst_pulse();
    rv = 2'b01; rl = 2'b00;
    for (int c = 0; c < 2; c++) begin
      set_slice(0, c);
      step();
    end
    tx = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t6_stall_ready", obs_ready, 2'b00);
      chk("t6_stall_dvalid", dstrm_dvalid, 0);
      chk("t6_stall_busy", sched_busy, 1);
    end
    tx = 1'b1;
    rst_pulse();
    rv = 2'b00;
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 1200; c++) begin
      if ($urandom_range(0, 49) == 0) gen2 = ~gen2;
      if ($urandom_range(0, 19) == 0) lp = (lp == 4'h1) ? 4'(($urandom_range(0, 1) == 0) ? 3 : 0) : 4'h1;
      tx  = ($urandom_range(0, 3) != 0);
      rv  = 2'($urandom_range(0, 3));
      rl  = 2'($urandom_range(0, 3));
      rcv = 2'($urandom_range(0, 3));
      for (int w = 0; w < (N * DW) / 32; w++) rd[w*32 +: 32] = $urandom;
      rc = $urandom;
      if ($urandom_range(0, 199) == 0) rst_pulse();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
